// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fft_pkg                                                          |
// | Shared Q-format defaults, divider FSM encoding and iteration-count helper. |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
package fft_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = DEF_WIDTH >> 1;

    // One quotient bit per iteration over the FRAC-shifted numerator
    localparam int ITERS = DEF_WIDTH + DEF_FRAC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic int calc_iters(input int width, input int frac);
        return width + frac;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_point_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fixed_point_divider                                              |
// | Signed Q-format divider, sign-magnitude restoring, one quotient bit/clock. |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module fixed_point_divider
    import fft_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = WIDTH >> 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int N_ITERS = calc_iters(WIDTH, FRAC);
    localparam int NW      = WIDTH + FRAC;
    localparam int CW      = (N_ITERS > 1) ? $clog2(N_ITERS) : 1;

    localparam logic [CW-1:0]    c_LAST    = CW'(N_ITERS - 1);
    localparam logic [NW-1:0]    c_POS_LIM = {{(FRAC + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic [NW-1:0]    c_NEG_LIM = {{FRAC{1'b0}}, 1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic [WIDTH-1:0] c_Q_MAX   = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [WIDTH-1:0] c_Q_MIN   = {1'b1, {(WIDTH - 1){1'b0}}};

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [NW-1:0]    num_q,   num_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] dmag_q,  dmag_d;
    logic             neg_q,   neg_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic             dbz_q,   dbz_d;
    logic             ovf_q,   ovf_d;

    logic [WIDTH:0]   w_trial;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [NW-1:0]    w_qmag;

    // Magnitude as unsigned WIDTH bits: the most negative value maps to 2^(WIDTH-1)
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    // num_q shifts numerator bits out of its MSB while quotient bits enter at the LSB
    assign w_trial = {rem_q, num_q[NW-1]};
    assign w_ge    = (w_trial >= {1'b0, dmag_q});
    assign w_diff  = w_trial[WIDTH-1:0] - dmag_q;
    assign w_qmag  = {num_q[NW-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            num_q   <= '0;
            rem_q   <= '0;
            dmag_q  <= '0;
            neg_q   <= 1'b0;
            quot_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            rem_q   <= rem_d;
            dmag_q  <= dmag_d;
            neg_q   <= neg_d;
            quot_q  <= quot_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        rem_d   = rem_q;
        dmag_d  = dmag_q;
        neg_d   = neg_q;
        quot_d  = quot_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    num_d  = {f_abs(dividend), {FRAC{1'b0}}};
                    dmag_d = f_abs(divisor);
                    rem_d  = '0;
                    cnt_d  = '0;
                    neg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    ovf_d  = 1'b0;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        quot_d  = dividend[WIDTH-1] ? c_Q_MIN : c_Q_MAX;
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end

            CALC: begin
                rem_d = w_ge ? w_diff : w_trial[WIDTH-1:0];
                num_d = w_qmag;
                if (cnt_q == c_LAST) begin
                    // Sign and saturation are applied to the final iteration's result directly
                    cnt_d   = '0;
                    state_d = DONE;
                    if (neg_q) begin
                        if (w_qmag > c_NEG_LIM) begin
                            quot_d = c_Q_MIN;
                            ovf_d  = 1'b1;
                        end else begin
                            quot_d = ~w_qmag[WIDTH-1:0] + WIDTH'(1);
                        end
                    end else begin
                        if (w_qmag > c_POS_LIM) begin
                            quot_d = c_Q_MAX;
                            ovf_d  = 1'b1;
                        end else begin
                            quot_d = w_qmag[WIDTH-1:0];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_fixed_point_divider                                           |
// | Randomised scoreboard bench for fixed_point_divider against a Q8.8 model.  |
// | Rev 1.0 : initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fixed_point_divider;

    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int LAT   = WIDTH + FRAC + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic             div_by_zero;
    logic             overflow;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             dbz;
        logic             ovf;
        int               lat;
        longint           acc;
    } exp_t;

    exp_t   sb[$];
    int     errors = 0;
    int     checks = 0;
    longint cyc    = 0;
    bit     ready_rand  = 1'b1;
    bit     ready_force = 1'b0;
    bit     mon_seen    = 1'b0;

    fixed_point_divider #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: exact rational arithmetic, C-style truncation, then clamp to the signed range
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t   e;
        longint n;
        longint q;
        e.lat = LAT;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        e.acc = 0;
        if (b == '0) begin
            e.lat = 1;
            e.dbz = 1'b1;
            e.q   = ($signed(a) >= 0) ? 16'h7FFF : 16'h8000;
            return e;
        end
        n = longint'($signed(a)) * (longint'(1) << FRAC);
        q = n / longint'($signed(b));
        if (q > 32767) begin
            e.q   = 16'h7FFF;
            e.ovf = 1'b1;
        end else if (q < -32768) begin
            e.q   = 16'h8000;
            e.ovf = 1'b1;
        end else begin
            e.q = q[WIDTH-1:0];
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Latency is counted with the accepting edge as edge 1
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   w = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        e     = model(a, b);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
    endtask

    task automatic drain(input int limit);
        int w = 0;
        while (sb.size() != 0 && w < limit) begin
            @(negedge clk);
            w++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    // Monitor: compares every cycle out_valid is high, so stalls also prove stability
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!mon_seen) begin
                        chk("latency", 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                        mon_seen = 1'b1;
                    end
                    chk("quotient", 32'(quotient), 32'(sb[0].q));
                    chk("div_by_zero", 32'(div_by_zero), 32'(sb[0].dbz));
                    chk("overflow", 32'(overflow), 32'(sb[0].ovf));
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        mon_seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               w;

        rst      = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
        rst = 1'b0;

        issue(16'h0300, 16'h0200);
        issue(16'hFD00, 16'h0200);
        issue(16'h0100, 16'h0300);
        issue(16'hFF00, 16'h0300);
        issue(16'h0100, 16'h0000);
        issue(16'hFF00, 16'h0000);
        issue(16'h7F00, 16'h0080);
        issue(16'h8000, 16'h0100);
        issue(16'h8000, 16'hFF00);
        issue(16'h0000, 16'hFD00);
        issue(16'h0000, 16'h0000);
        issue(16'hFFFF, 16'h7FFF);
        drain(2000);

        // Hold the result in DONE for ten cycles, then release with a single out_ready pulse
        ready_rand  = 1'b0;
        ready_force = 1'b0;
        issue(16'h0300, 16'h0200);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("stall_valid_timeout", 32'(out_valid), 32'd1);
        repeat (10) @(negedge clk);
        chk("stall_still_valid", 32'(out_valid), 32'd1);
        ready_force = 1'b1;
        @(posedge clk);
        #2;
        ready_force = 1'b0;
        issue(16'hFD00, 16'h0300);
        ready_force = 1'b1;
        drain(200);
        ready_rand = 1'b1;

        // Reset lands at iteration 12 and must discard the operation
        issue(16'h0300, 16'h0200);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        issue(16'h0200, 16'h0100);
        drain(200);

        for (int i = 0; i < 150; i++) begin
            a = WIDTH'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = WIDTH'($signed(WIDTH'($urandom_range(0, 255))) - 128);
                3:       b = (a == '0) ? 16'h0100 : a;
                default: b = WIDTH'($urandom);
            endcase
            if ($urandom_range(0, 9) == 0) a = '0;
            issue(a, b);
        end
        drain(4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
